// File: rtl/lb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lb_pkg : shared constants and types for the 3-entry leaderboard  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package lb_pkg;

  localparam int TIME_W   = 22;
  localparam int LB_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_SHIFT   = 2'd2
  } state_e;

  typedef logic [1:0] rank_t;

  function automatic logic [LB_DEPTH-1:0] rank_onehot(input rank_t r);
    rank_onehot = {{(LB_DEPTH-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lb_sound_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lb_sound_timer : one-hot sound pulse of SOUND_CYC clk cycles     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lb_sound_timer
  import lb_pkg::*;
#(
  parameter int SOUND_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  rank_t               rank,
  output logic [LB_DEPTH-1:0] sound
);

  localparam int CNT_W = $clog2(SOUND_CYC + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LB_DEPTH-1:0] hot_q, hot_d;

  // A fresh start always reloads the full length and replaces the one-hot.
  always_comb begin
    cnt_d = cnt_q;
    hot_d = hot_q;
    if (stop) begin
      cnt_d = '0;
      hot_d = '0;
    end else if (start) begin
      cnt_d = CNT_W'(SOUND_CYC);
      hot_d = rank_onehot(rank);
    end else if (hot_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        hot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hot_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hot_q <= hot_d;
    end
  end

  assign sound = hot_q;

endmodule
`default_nettype wire

// File: rtl/leaderboard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | leaderboard_ctrl : best-3 stopwatch times with placement sounds; |
// | optional LEADERBOARD_CLEAR_EN adds clear_req.  Rev 1.0           |
// +------------------------------------------------------------------+
module leaderboard_ctrl #(
  parameter int TIME_W    = lb_pkg::TIME_W,
  parameter int SOUND_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TIME_W-1:0] time_in,
  input  logic              time_valid,
  output logic              time_ready,
  input  logic [1:0]        stopwatch_mode,
  input  logic [1:0]        display_sel,
  output logic [TIME_W-1:0] leaderboard_number,
  output logic              entry_valid,
  output logic              signal_sound_1,
  output logic              signal_sound_2,
  output logic              signal_sound_3,
  output logic              busy
`ifdef LEADERBOARD_CLEAR_EN
  ,
  input  logic              clear_req
`endif
);
  import lb_pkg::*;

  state_e              state_q, state_d;
  rank_t               k_q, k_d;
  logic [TIME_W-1:0]   cand_q, cand_d;
  logic [TIME_W-1:0]   tbl_q [LB_DEPTH];
  logic [TIME_W-1:0]   tbl_d [LB_DEPTH];
  logic [LB_DEPTH-1:0] vld_q, vld_d;
  logic [TIME_W-1:0]   num_q, num_d;
  logic                ev_q, ev_d;

  logic                w_accept;
  logic                w_clear;
  logic                w_hit;
  logic                w_snd_start;
  logic                w_snd_stop;
  logic [LB_DEPTH-1:0] w_sound;

  assign time_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign w_accept   = time_valid && time_ready && (stopwatch_mode == 2'b01)
                      && (time_in != '0);
  assign w_hit      = !vld_q[k_q] || (cand_q < tbl_q[k_q]);

`ifdef LEADERBOARD_CLEAR_EN
  logic clr_pend_q, clr_pend_d;

  // A clear seen while busy is remembered and applied on the first IDLE cycle.
  assign w_clear = (clear_req || clr_pend_q) && (state_q == ST_IDLE);

  always_comb begin
    clr_pend_d = clr_pend_q;
    if (w_clear) begin
      clr_pend_d = 1'b0;
    end else if (clear_req) begin
      clr_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_pend_q <= 1'b0;
    end else begin
      clr_pend_q <= clr_pend_d;
    end
  end
`else
  assign w_clear = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cand_d      = cand_q;
    tbl_d       = tbl_q;
    vld_d       = vld_q;
    w_snd_start = 1'b0;
    w_snd_stop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_clear) begin
          vld_d      = '0;
          w_snd_stop = 1'b1;
        end else if (w_accept) begin
          cand_d  = time_in;
          k_d     = '0;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        // Strict compare: an equal time keeps scanning and so ranks below.
        if (w_hit) begin
          state_d = ST_SHIFT;
        end else if (k_q == rank_t'(LB_DEPTH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        for (int j = LB_DEPTH - 1; j > 0; j--) begin
          if (rank_t'(j) > k_q) begin
            tbl_d[j] = tbl_q[j-1];
            vld_d[j] = vld_q[j-1];
          end
        end
        tbl_d[k_q]  = cand_q;
        vld_d[k_q]  = 1'b1;
        w_snd_start = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    num_d = '0;
    ev_d  = 1'b0;
    for (int i = 0; i < LB_DEPTH; i++) begin
      if ((display_sel == 2'(i)) && vld_q[i]) begin
        num_d = tbl_q[i];
        ev_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      cand_q  <= '0;
      tbl_q   <= '{default: '0};
      vld_q   <= '0;
      num_q   <= '0;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cand_q  <= cand_d;
      tbl_q   <= tbl_d;
      vld_q   <= vld_d;
      num_q   <= num_d;
      ev_q    <= ev_d;
    end
  end

  assign leaderboard_number = num_q;
  assign entry_valid        = ev_q;

  lb_sound_timer #(
    .SOUND_CYC (SOUND_CYC)
  ) u_sound (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_snd_start),
    .stop  (w_snd_stop),
    .rank  (k_q),
    .sound (w_sound)
  );

  assign signal_sound_1 = w_sound[0];
  assign signal_sound_2 = w_sound[1];
  assign signal_sound_3 = w_sound[2];

endmodule
`default_nettype wire
